// File: rtl/mem_2r2w_ctrl_pkg.sv
// Shared types and helpers for the 2R2W SRAM front-end controller.
package mem_2r2w_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      INIT = 2'd1,
      RUN  = 2'd2
   } state_t;

   // Init pattern for one word; the caller truncates to the data width.
   function automatic int init_val(input int addr, input int strt, input int incr);
      return strt + addr * incr;
   endfunction

endpackage

// File: rtl/mem_2r2w_ctrl_shift.sv
// Fixed-latency delay line for {valid, bypass_hit, bypass_data}; DELAY=0 is a wire.
module mem_2r2w_ctrl_shift #(
   parameter int BITDATA = 1,
   parameter int DELAY   = 0
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               vld_in,
   input  logic               hit_in,
   input  logic [BITDATA-1:0] dat_in,
   output logic               vld_out,
   output logic               hit_out,
   output logic [BITDATA-1:0] dat_out
);

   localparam int W    = BITDATA + 2;
   localparam int NP   = (DELAY == 0) ? 1 : DELAY;
   localparam int LAST = (DELAY == 0) ? 0 : DELAY - 1;

   logic [W-1:0]         din;
   logic [W-1:0]         dout;
   logic [NP-1:0][W-1:0] pipe;

   assign din = {vld_in, hit_in, dat_in};

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pipe <= '0;
      end else begin
         pipe[0] <= din;
         for (int i = 1; i < NP; i++) pipe[i] <= pipe[i-1];
      end
   end

   assign dout = (DELAY == 0) ? din : pipe[LAST];
   assign {vld_out, hit_out, dat_out} = dout;

endmodule

// File: rtl/mem_2r2w_ctrl.sv
// 2R2W SRAM front-end: post-reset init, write collision resolve, latency-aligned read return.
// Optional same-cycle write-to-read bypass: define MEM_2R2W_CTRL_BYPASS_EN.
//
//  state | meaning
//  IDLE  | waiting for mem_ready after reset
//  INIT  | writing init pattern, one word per cycle on port 2
//  RUN   | serving client requests (terminal until reset)
module mem_2r2w_ctrl
   import mem_2r2w_ctrl_pkg::*;
#(
   parameter int NUMADDR    = 8,
   parameter int BITADDR    = 3,
   parameter int BITDATA    = 1,
   parameter int SRAM_DELAY = 0,
   parameter int RSTINIT    = 0,
   parameter int RSTSTRT    = 0,
   parameter int RSTINCR    = 0
) (
   input  logic               clk,
   input  logic               rst,
   output logic               ready,
   output logic               err_drop,
   input  logic               rd_req_0,
   input  logic [BITADDR-1:0] rd_adr_0,
   output logic               rd_vld_0,
   output logic [BITDATA-1:0] rd_dout_0,
   input  logic               rd_req_1,
   input  logic [BITADDR-1:0] rd_adr_1,
   output logic               rd_vld_1,
   output logic [BITDATA-1:0] rd_dout_1,
   input  logic               wr_req_2,
   input  logic [BITADDR-1:0] wr_adr_2,
   input  logic [BITDATA-1:0] wr_din_2,
   input  logic               wr_req_3,
   input  logic [BITADDR-1:0] wr_adr_3,
   input  logic [BITDATA-1:0] wr_din_3,
   input  logic               mem_ready,
   output logic               mem_read_0,
   output logic [BITADDR-1:0] mem_rd_adr_0,
   input  logic [BITDATA-1:0] mem_rd_dout_0,
   output logic               mem_read_1,
   output logic [BITADDR-1:0] mem_rd_adr_1,
   input  logic [BITDATA-1:0] mem_rd_dout_1,
   output logic               mem_write_2,
   output logic [BITADDR-1:0] mem_wr_adr_2,
   output logic [BITDATA-1:0] mem_wr_din_2,
   output logic               mem_write_3,
   output logic [BITADDR-1:0] mem_wr_adr_3,
   output logic [BITDATA-1:0] mem_wr_din_3,
   output logic [BITADDR-1:0] mem_select_adr
);

   state_t             state, state_nxt;
   logic [BITADDR-1:0] cnt;
   logic               cnt_last;
   logic               any_req;
   logic               hit_0, hit_1;
   logic [BITDATA-1:0] byp_0, byp_1;
   logic               s_vld_0, s_hit_0, s_vld_1, s_hit_1;
   logic [BITDATA-1:0] s_dat_0, s_dat_1;

   assign cnt_last       = (cnt == BITADDR'(NUMADDR - 1));
   assign any_req        = rd_req_0 | rd_req_1 | wr_req_2 | wr_req_3;
   assign mem_select_adr = '0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (mem_ready) state_nxt = (RSTINIT != 0) ? INIT : RUN;
         INIT:    if (cnt_last)  state_nxt = RUN;
         RUN:     state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ready    <= 1'b0;
         err_drop <= 1'b0;
         cnt      <= '0;
      end else begin
         ready <= (state == RUN);
         if (state == INIT) cnt <= cnt + 1'b1;
         if (!ready && any_req) err_drop <= 1'b1;
      end
   end

   // Client traffic is gated by the registered ready, so ready=0 always means dropped.
   always_comb begin
      mem_read_0   = 1'b0;
      mem_rd_adr_0 = '0;
      mem_read_1   = 1'b0;
      mem_rd_adr_1 = '0;
      mem_write_2  = 1'b0;
      mem_wr_adr_2 = '0;
      mem_wr_din_2 = '0;
      mem_write_3  = 1'b0;
      mem_wr_adr_3 = '0;
      mem_wr_din_3 = '0;
      if (state == INIT) begin
         mem_write_2  = 1'b1;
         mem_wr_adr_2 = cnt;
         mem_wr_din_2 = BITDATA'(init_val(int'(cnt), RSTSTRT, RSTINCR));
      end else if (ready) begin
         mem_read_0   = rd_req_0;
         mem_rd_adr_0 = rd_adr_0;
         mem_read_1   = rd_req_1;
         mem_rd_adr_1 = rd_adr_1;
         mem_write_2  = wr_req_2 && !(wr_req_3 && (wr_adr_3 == wr_adr_2));
         mem_wr_adr_2 = wr_adr_2;
         mem_wr_din_2 = wr_din_2;
         mem_write_3  = wr_req_3;
         mem_wr_adr_3 = wr_adr_3;
         mem_wr_din_3 = wr_din_3;
      end
   end

`ifdef MEM_2R2W_CTRL_BYPASS_EN
   always_comb begin
      hit_0 = 1'b0;
      byp_0 = '0;
      hit_1 = 1'b0;
      byp_1 = '0;
      if (mem_read_0 && mem_write_3 && (mem_wr_adr_3 == rd_adr_0)) begin
         hit_0 = 1'b1;
         byp_0 = mem_wr_din_3;
      end else if (mem_read_0 && mem_write_2 && (mem_wr_adr_2 == rd_adr_0)) begin
         hit_0 = 1'b1;
         byp_0 = mem_wr_din_2;
      end
      if (mem_read_1 && mem_write_3 && (mem_wr_adr_3 == rd_adr_1)) begin
         hit_1 = 1'b1;
         byp_1 = mem_wr_din_3;
      end else if (mem_read_1 && mem_write_2 && (mem_wr_adr_2 == rd_adr_1)) begin
         hit_1 = 1'b1;
         byp_1 = mem_wr_din_2;
      end
   end
`else
   assign hit_0 = 1'b0;
   assign byp_0 = '0;
   assign hit_1 = 1'b0;
   assign byp_1 = '0;
`endif

   mem_2r2w_ctrl_shift #(.BITDATA(BITDATA), .DELAY(SRAM_DELAY)) u_shift_0 (
      .clk(clk), .rst(rst),
      .vld_in(mem_read_0), .hit_in(hit_0), .dat_in(byp_0),
      .vld_out(s_vld_0), .hit_out(s_hit_0), .dat_out(s_dat_0)
   );

   mem_2r2w_ctrl_shift #(.BITDATA(BITDATA), .DELAY(SRAM_DELAY)) u_shift_1 (
      .clk(clk), .rst(rst),
      .vld_in(mem_read_1), .hit_in(hit_1), .dat_in(byp_1),
      .vld_out(s_vld_1), .hit_out(s_hit_1), .dat_out(s_dat_1)
   );

   assign rd_vld_0  = s_vld_0;
   assign rd_dout_0 = s_vld_0 ? (s_hit_0 ? s_dat_0 : mem_rd_dout_0) : '0;
   assign rd_vld_1  = s_vld_1;
   assign rd_dout_1 = s_vld_1 ? (s_hit_1 ? s_dat_1 : mem_rd_dout_1) : '0;

endmodule

// File: tb/tb_mem_2r2w_ctrl.sv
// Bench for mem_2r2w_ctrl: directed init/collision/reset cases plus random RUN traffic vs. a word-level model.
module tb_mem_2r2w_ctrl;

   localparam int NA   = 8;
   localparam int BA   = 3;
   localparam int BD   = 8;
   localparam int SD   = 2;
   localparam int STRT = 3;
   localparam int INCR = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          ready, err_drop;
   logic          rd_req_0 = 1'b0, rd_req_1 = 1'b0;
   logic [BA-1:0] rd_adr_0 = '0, rd_adr_1 = '0;
   logic          rd_vld_0, rd_vld_1;
   logic [BD-1:0] rd_dout_0, rd_dout_1;
   logic          wr_req_2 = 1'b0, wr_req_3 = 1'b0;
   logic [BA-1:0] wr_adr_2 = '0, wr_adr_3 = '0;
   logic [BD-1:0] wr_din_2 = '0, wr_din_3 = '0;
   logic          mem_ready = 1'b1;
   logic          mem_read_0, mem_read_1, mem_write_2, mem_write_3;
   logic [BA-1:0] mem_rd_adr_0, mem_rd_adr_1, mem_wr_adr_2, mem_wr_adr_3, mem_select_adr;
   logic [BD-1:0] mem_rd_dout_0, mem_rd_dout_1, mem_wr_din_2, mem_wr_din_3;

   int n_chk = 0;
   int n_bad = 0;
   int cyc   = 0;

   typedef struct {
      int            due;
      logic [BD-1:0] dat;
   } exp_t;

   exp_t q0[$];
   exp_t q1[$];
   int   ref_mem [NA];

   always #5 clk = ~clk;

   mem_2r2w_ctrl #(
      .NUMADDR(NA), .BITADDR(BA), .BITDATA(BD), .SRAM_DELAY(SD),
      .RSTINIT(1), .RSTSTRT(STRT), .RSTINCR(INCR)
   ) dut (
      .clk(clk), .rst(rst), .ready(ready), .err_drop(err_drop),
      .rd_req_0(rd_req_0), .rd_adr_0(rd_adr_0), .rd_vld_0(rd_vld_0), .rd_dout_0(rd_dout_0),
      .rd_req_1(rd_req_1), .rd_adr_1(rd_adr_1), .rd_vld_1(rd_vld_1), .rd_dout_1(rd_dout_1),
      .wr_req_2(wr_req_2), .wr_adr_2(wr_adr_2), .wr_din_2(wr_din_2),
      .wr_req_3(wr_req_3), .wr_adr_3(wr_adr_3), .wr_din_3(wr_din_3),
      .mem_ready(mem_ready),
      .mem_read_0(mem_read_0), .mem_rd_adr_0(mem_rd_adr_0), .mem_rd_dout_0(mem_rd_dout_0),
      .mem_read_1(mem_read_1), .mem_rd_adr_1(mem_rd_adr_1), .mem_rd_dout_1(mem_rd_dout_1),
      .mem_write_2(mem_write_2), .mem_wr_adr_2(mem_wr_adr_2), .mem_wr_din_2(mem_wr_din_2),
      .mem_write_3(mem_write_3), .mem_wr_adr_3(mem_wr_adr_3), .mem_wr_din_3(mem_wr_din_3),
      .mem_select_adr(mem_select_adr)
   );

   // Macro stand-in: read-before-write array, SD-cycle read pipeline.
   logic [BD-1:0] macro [NA];
   logic [BD-1:0] rp0 [SD];
   logic [BD-1:0] rp1 [SD];

   always @(posedge clk) begin
      rp0[0] <= macro[mem_rd_adr_0];
      rp1[0] <= macro[mem_rd_adr_1];
      for (int i = 1; i < SD; i++) begin
         rp0[i] <= rp0[i-1];
         rp1[i] <= rp1[i-1];
      end
      if (mem_write_2) macro[mem_wr_adr_2] <= mem_wr_din_2;
      if (mem_write_3) macro[mem_wr_adr_3] <= mem_wr_din_3;
   end

   assign mem_rd_dout_0 = rp0[SD-1];
   assign mem_rd_dout_1 = rp1[SD-1];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic ref_init();
      for (int a = 0; a < NA; a++) ref_mem[a] = (STRT + a * INCR) & 8'hFF;
   endtask

   function automatic int ref_read(input int a, input bit w2, input int a2, input int d2,
                                   input bit w3, input int a3, input int d3);
`ifdef MEM_2R2W_CTRL_BYPASS_EN
      if (w3 && a3 == a) return d3;
      if (w2 && a2 == a) return d2;
`endif
      return ref_mem[a];
   endfunction

   // Called at posedge+1; walks ncyc cycles of the post-release sequence (c=0 is right after the first edge).
   task automatic init_run(input int ncyc, input bit poke);
      for (int c = 0; c < ncyc; c++) begin
         if (poke && c == 3) begin
            rd_req_1 = 1'b1;
            rd_adr_1 = 3'd2;
         end
         #1;
         chk("init_write_2", 32'(mem_write_2), 32'(c < NA));
         if (c < NA) begin
            chk("init_adr_2", 32'(mem_wr_adr_2), c);
            chk("init_din_2", 32'(mem_wr_din_2), (STRT + c * INCR) & 8'hFF);
         end
         chk("init_write_3", 32'(mem_write_3), 0);
         chk("init_read_1", 32'(mem_read_1), 0);
         chk("init_vld_0", 32'(rd_vld_0), 0);
         chk("init_vld_1", 32'(rd_vld_1), 0);
         chk("init_ready", 32'(ready), 32'(c >= NA + 1));
         if (c == 0) chk("init_err_clear", 32'(err_drop), 0);
         @(posedge clk);
         #1;
         rd_req_1 = 1'b0;
         if (poke && c == 3) chk("err_drop_set", 32'(err_drop), 1);
      end
   endtask

   task automatic run_cyc(input bit r0, input int a0, input bit r1, input int a1,
                          input bit w2, input int a2, input int d2,
                          input bit w3, input int a3, input int d3);
      exp_t e;
      rd_req_0 = r0; rd_adr_0 = BA'(a0);
      rd_req_1 = r1; rd_adr_1 = BA'(a1);
      wr_req_2 = w2; wr_adr_2 = BA'(a2); wr_din_2 = BD'(d2);
      wr_req_3 = w3; wr_adr_3 = BA'(a3); wr_din_3 = BD'(d3);
      #1;
      if (r0) begin
         e.due = cyc + SD;
         e.dat = BD'(ref_read(a0, w2, a2, d2, w3, a3, d3));
         q0.push_back(e);
      end
      if (r1) begin
         e.due = cyc + SD;
         e.dat = BD'(ref_read(a1, w2, a2, d2, w3, a3, d3));
         q1.push_back(e);
      end
      if (q0.size() > 0 && q0[0].due == cyc) begin
         chk("rd_vld_0", 32'(rd_vld_0), 1);
         chk("rd_dout_0", 32'(rd_dout_0), 32'(q0[0].dat));
         void'(q0.pop_front());
      end else begin
         chk("rd_vld_0_idle", 32'(rd_vld_0), 0);
         chk("rd_dout_0_idle", 32'(rd_dout_0), 0);
      end
      if (q1.size() > 0 && q1[0].due == cyc) begin
         chk("rd_vld_1", 32'(rd_vld_1), 1);
         chk("rd_dout_1", 32'(rd_dout_1), 32'(q1[0].dat));
         void'(q1.pop_front());
      end else begin
         chk("rd_vld_1_idle", 32'(rd_vld_1), 0);
         chk("rd_dout_1_idle", 32'(rd_dout_1), 0);
      end
      chk("mem_read_0", 32'(mem_read_0), 32'(r0));
      chk("mem_read_1", 32'(mem_read_1), 32'(r1));
      if (r0) chk("mem_rd_adr_0", 32'(mem_rd_adr_0), a0);
      if (r1) chk("mem_rd_adr_1", 32'(mem_rd_adr_1), a1);
      chk("mem_write_2", 32'(mem_write_2), 32'(w2 && !(w3 && a2 == a3)));
      chk("mem_write_3", 32'(mem_write_3), 32'(w3));
      if (w3) chk("mem_wr_din_3", 32'(mem_wr_din_3), d3);
      if (w2) ref_mem[a2] = d2 & 8'hFF;
      if (w3) ref_mem[a3] = d3 & 8'hFF;
      @(posedge clk);
      #1;
      cyc++;
   endtask

   task automatic idle_cyc(input int n);
      for (int i = 0; i < n; i++) run_cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      // Reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_ready", 32'(ready), 0);
      chk("rst_err_drop", 32'(err_drop), 0);
      chk("rst_write_2", 32'(mem_write_2), 0);
      chk("rst_read_0", 32'(mem_read_0), 0);
      chk("rst_vld_0", 32'(rd_vld_0), 0);
      chk("select_adr", 32'(mem_select_adr), 0);

      // Init sequence, with a read request poked in mid-init
      rst = 1'b1;
      ref_init();
      @(posedge clk);
      #1;
      init_run(NA + 2, 1'b1);

      // Directed RUN cases
      run_cyc(1, 7, 1, 0, 0, 0, 0, 0, 0, 0);
      run_cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      run_cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      run_cyc(1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
      run_cyc(0, 0, 0, 0, 1, 5, 8'hAA, 1, 5, 8'h55);
      run_cyc(0, 0, 1, 5, 1, 2, 8'h11, 0, 0, 0);
      run_cyc(1, 2, 0, 0, 0, 0, 0, 1, 2, 8'h22);
      run_cyc(1, 2, 0, 0, 0, 0, 0, 0, 0, 0);
      idle_cyc(SD + 1);

      // Random RUN traffic
      for (int i = 0; i < 400; i++) begin
         run_cyc(1'($urandom_range(0, 1)), int'($urandom_range(0, NA - 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NA - 1)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NA - 1)), int'($urandom_range(0, 255)),
                 1'($urandom_range(0, 1)), int'($urandom_range(0, NA - 1)), int'($urandom_range(0, 255)));
      end
      idle_cyc(SD + 1);
      chk("drain_empty", 32'(q0.size() + q1.size()), 0);
      chk("err_drop_sticky", 32'(err_drop), 1);

      // Reset with reads in flight
      run_cyc(1, 1, 1, 3, 0, 0, 0, 0, 0, 0);
      rd_req_0 = 1'b1;
      rd_req_1 = 1'b1;
      rst = 1'b0;
      #1;
      chk("rst_flight_vld_0", 32'(rd_vld_0), 0);
      chk("rst_flight_vld_1", 32'(rd_vld_1), 0);
      chk("rst_flight_ready", 32'(ready), 0);
      chk("rst_flight_err", 32'(err_drop), 0);
      chk("rst_flight_read_0", 32'(mem_read_0), 0);
      rd_req_0 = 1'b0;
      rd_req_1 = 1'b0;
      q0.delete();
      q1.delete();
      @(posedge clk);
      #1;

      // Release, then reset again at init cnt=4
      rst = 1'b1;
      @(posedge clk);
      #1;
      init_run(4, 1'b0);
      #1;
      chk("mid_init_adr", 32'(mem_wr_adr_2), 4);
      rst = 1'b0;
      #1;
      chk("mid_rst_write_2", 32'(mem_write_2), 0);
      chk("mid_rst_ready", 32'(ready), 0);
      chk("mid_rst_vld_0", 32'(rd_vld_0), 0);
      @(posedge clk);
      #1;

      // Clean restart from address 0, then confirm re-initialised contents
      rst = 1'b1;
      ref_init();
      @(posedge clk);
      #1;
      init_run(NA + 2, 1'b0);
      chk("restart_err_drop", 32'(err_drop), 0);
      run_cyc(1, 7, 1, 5, 0, 0, 0, 0, 0, 0);
      idle_cyc(SD + 1);
      chk("final_drain", 32'(q0.size() + q1.size()), 0);

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
